// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the architectural PC, runs a single-outstanding req/gnt/rvalid
// fetch to instruction memory and fills the IF/ID register, with a one-entry hold buffer.
module if_fetch_stage #(
    parameter int unsigned     BW       = 32,
    parameter logic [BW-1:0]   RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [BW-1:0] pc_next_i,
    input  logic          flush_i,
    input  logic          stall_i,
    output logic [BW-1:0] pc_o,
    output logic [BW-1:0] pc_plus4_o,
    output logic          imem_req_o,
    output logic [BW-1:0] imem_addr_o,
    input  logic          imem_gnt_i,
    input  logic          imem_rvalid_i,
    input  logic [BW-1:0] imem_rdata_i,
    output logic          ifid_valid_o,
    output logic [BW-1:0] ifid_pc_o,
    output logic [BW-1:0] ifid_inst_o
);

    typedef enum logic [1:0] {StReq, StWait, StHold} state_e;

    state_e        r_state, w_state_d;
    logic          r_kill, w_kill_d;
    logic [BW-1:0] r_pc, w_pc_d;
    logic [BW-1:0] r_hold_inst;
    logic          r_ifid_valid;
    logic [BW-1:0] r_ifid_pc, r_ifid_inst;

    logic          w_accept;
    logic          w_resp_ok;
    logic          w_deliver;
    logic          w_hold_load;
    logic [BW-1:0] w_dlv_inst;

    assign w_accept    = ~stall_i | ~r_ifid_valid;
    assign w_resp_ok   = (r_state == StWait) & imem_rvalid_i & ~r_kill & ~flush_i;
    assign w_deliver   = w_accept & (w_resp_ok | ((r_state == StHold) & ~flush_i));
    assign w_hold_load = w_resp_ok & ~w_accept;
    assign w_dlv_inst  = (r_state == StHold) ? r_hold_inst : imem_rdata_i;
    // PC only moves on delivery or flush, so r_pc is also the PC of a buffered instruction.
    assign w_pc_d      = (flush_i | w_deliver) ? pc_next_i : r_pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StReq;
            r_kill  <= 1'b0;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_d;
            r_kill  <= w_kill_d;
            r_pc    <= w_pc_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_kill_d  = r_kill;
        case (r_state)
            StReq: begin
                if (imem_gnt_i) begin
                    w_state_d = StWait;
                    w_kill_d  = flush_i;
                end
            end
            StWait: begin
                if (imem_rvalid_i) begin
                    w_kill_d  = 1'b0;
                    w_state_d = w_hold_load ? StHold : StReq;
                end else if (flush_i) begin
                    w_kill_d  = 1'b1;
                end
            end
            StHold: begin
                if (flush_i || w_accept) begin
                    w_state_d = StReq;
                end
            end
            default: begin
                w_state_d = StReq;
                w_kill_d  = 1'b0;
            end
        endcase
    end

    always_comb begin
        imem_req_o  = rst & (r_state == StReq);
        imem_addr_o = r_pc;
        pc_o        = r_pc;
        pc_plus4_o  = r_pc + BW'(4);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold_inst <= '0;
        end else if (w_hold_load) begin
            r_hold_inst <= imem_rdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ifid_valid <= 1'b0;
            r_ifid_pc    <= '0;
            r_ifid_inst  <= '0;
        end else if (flush_i) begin
            r_ifid_valid <= 1'b0;
        end else if (w_accept) begin
            r_ifid_valid <= w_deliver;
            if (w_deliver) begin
                r_ifid_pc   <= r_pc;
                r_ifid_inst <= w_dlv_inst;
            end
        end
    end

    assign ifid_valid_o = r_ifid_valid;
    assign ifid_pc_o    = r_ifid_pc;
    assign ifid_inst_o  = r_ifid_inst;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios then randomized traffic, all checked against a
// transaction-level model (epoch-tagged fetches, one-entry pending buffer, in-order delivery).
module tb_if_fetch_stage;

    localparam int unsigned BW       = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_next_i;
    logic        flush_i, stall_i;
    logic [31:0] pc_o, pc_plus4_o;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i, imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        ifid_valid_o;
    logic [31:0] ifid_pc_o, ifid_inst_o;

    always #5 clk = ~clk;

    if_fetch_stage #(.BW(BW), .RESET_PC(RESET_PC)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_next_i    (pc_next_i),
        .flush_i      (flush_i),
        .stall_i      (stall_i),
        .pc_o         (pc_o),
        .pc_plus4_o   (pc_plus4_o),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_gnt_i   (imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i (imem_rdata_i),
        .ifid_valid_o (ifid_valid_o),
        .ifid_pc_o    (ifid_pc_o),
        .ifid_inst_o  (ifid_inst_o)
    );

    int n_vec = 0;
    int n_err = 0;

    // memory environment
    int          gnt_delay = 0, lat = 1, gnt_cnt = 0, mem_cnt = 0;
    bit          mem_busy = 1'b0, rnd_mem = 1'b0;
    logic [31:0] mem_addr = '0;

    // reference model
    logic [31:0] m_pc, m_req_pc, m_buf_pc, m_ifid_pc, m_ifid_inst;
    bit          m_valid, m_out, m_buf;
    int unsigned m_epoch = 0, m_tag = 0;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return 32'h13 | (a << 18) | ((a != 32'h0) ? 32'h80 : 32'h0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc        = RESET_PC;
        m_valid     = 1'b0;
        m_ifid_pc   = '0;
        m_ifid_inst = '0;
        m_out       = 1'b0;
        m_buf       = 1'b0;
    endtask

    task automatic check_all();
        bit er;
        er = rst && !m_out && !m_buf;
        chk("pc", pc_o, m_pc);
        chk("pc_plus4", pc_plus4_o, m_pc + 32'd4);
        chk("req", 32'(imem_req_o), 32'(er));
        if (er) chk("addr", imem_addr_o, m_pc);
        chk("ifid_valid", 32'(ifid_valid_o), 32'(m_valid));
        chk("ifid_pc", ifid_pc_o, m_ifid_pc);
        chk("ifid_inst", ifid_inst_o, m_ifid_inst);
    endtask

    // One clock: check state, drive inputs, advance model, cross the rising edge.
    task automatic tick(input bit fl, input bit st, input bit use_t, input logic [31:0] tgt);
        logic        req_s;
        logic [31:0] addr_s, nxt, dp;
        bit          rv, g, er, accept, resp, good, dlv;
        check_all();
        nxt       = use_t ? tgt : m_pc + 32'd4;
        flush_i   = fl;
        stall_i   = st;
        pc_next_i = nxt;
        rv        = mem_busy && (mem_cnt == 0);
        imem_rvalid_i = rv;
        imem_rdata_i  = rv ? inst_of(mem_addr) : $urandom;
        req_s  = imem_req_o;
        addr_s = imem_addr_o;
        if (rnd_mem) g = req_s && !mem_busy && ($urandom_range(0, 2) != 0);
        else         g = req_s && !mem_busy && (gnt_cnt >= gnt_delay);
        imem_gnt_i = g;
        er = rst && !m_out && !m_buf;
        if (rst) begin
            accept = !st || !m_valid;
            resp   = m_out && rv;
            good   = resp && (m_tag == m_epoch) && !fl;
            dlv    = 1'b0;
            dp     = '0;
            if (fl) m_buf = 1'b0;
            else if (m_buf && accept) begin dlv = 1'b1; dp = m_buf_pc; m_buf = 1'b0; end
            else if (good && accept) begin dlv = 1'b1; dp = m_req_pc; end
            else if (good) begin m_buf = 1'b1; m_buf_pc = m_req_pc; end
            if (fl) m_valid = 1'b0;
            else if (accept) begin
                m_valid = dlv;
                if (dlv) begin m_ifid_pc = dp; m_ifid_inst = inst_of(dp); end
            end
            if (resp) m_out = 1'b0;
            if (er && g) begin m_out = 1'b1; m_tag = m_epoch; m_req_pc = m_pc; end
            if (fl) m_epoch++;
            if (fl || dlv) m_pc = nxt;
        end
        @(posedge clk);
        if (rv) mem_busy = 1'b0;
        else if (mem_busy) mem_cnt--;
        if (g) begin
            mem_busy = 1'b1;
            mem_cnt  = rnd_mem ? $urandom_range(0, 2) : lat - 1;
            mem_addr = addr_s;
        end
        gnt_cnt = (req_s && !g) ? gnt_cnt + 1 : 0;
        @(negedge clk);
    endtask

    task automatic step();
        tick(1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        int          k;
        logic [31:0] p, r;
        bit          fl, st, ut;

        rst = 1'b0; flush_i = 1'b0; stall_i = 1'b0; pc_next_i = '0;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
        model_reset();
        @(negedge clk);
        step();
        step();
        rst = 1'b1;
        #1;

        // zero-wait memory: one instruction every two cycles
        step(); step();
        chk("first_valid", 32'(ifid_valid_o), 32'd1);
        chk("first_pc", ifid_pc_o, 32'h0);
        chk("first_inst", ifid_inst_o, 32'h0000_0013);
        step();
        chk("bubble", 32'(ifid_valid_o), 32'd0);
        step();
        chk("second_pc", ifid_pc_o, 32'h4);
        chk("second_inst", ifid_inst_o, 32'h0010_0093);
        step(); step();
        chk("third_pc", ifid_pc_o, 32'h8);

        // slow memory: gnt after 2 cycles, data 3 cycles after gnt
        gnt_delay = 2; lat = 3;
        for (int i = 0; i < 24; i++) step();

        // stall while the next fetch returns -> hold buffer
        gnt_delay = 0; lat = 1;
        k = 0;
        while (!(m_valid && !m_out && !m_buf) && k < 20) begin step(); k++; end
        chk("sync_hold", 32'(k < 20), 32'd1);
        p = ifid_pc_o;
        tick(1'b0, 1'b1, 1'b0, 32'h0);
        tick(1'b0, 1'b1, 1'b0, 32'h0);
        chk("hold_pc", ifid_pc_o, p);
        chk("hold_noreq", 32'(imem_req_o), 32'd0);
        tick(1'b0, 1'b1, 1'b0, 32'h0);
        chk("hold_pc2", ifid_pc_o, p);
        step();
        chk("unhold_pc", ifid_pc_o, p + 32'd4);
        chk("unhold_valid", 32'(ifid_valid_o), 32'd1);
        chk("next_addr", imem_addr_o, p + 32'd8);

        // flush while waiting for data
        lat = 3;
        k = 0;
        while (!m_out && k < 20) begin step(); k++; end
        tick(1'b1, 1'b0, 1'b1, 32'h100);
        chk("flush_valid", 32'(ifid_valid_o), 32'd0);
        chk("flush_pc", pc_o, 32'h100);
        k = 0;
        while (!imem_req_o && k < 20) begin step(); k++; end
        chk("flush_addr", imem_addr_o, 32'h100);
        k = 0;
        while (!ifid_valid_o && k < 20) begin step(); k++; end
        chk("flush_first_pc", ifid_pc_o, 32'h100);
        chk("flush_first_inst", ifid_inst_o, inst_of(32'h100));

        // flush beats stall
        lat = 1;
        k = 0;
        while (!m_valid && k < 20) begin step(); k++; end
        tick(1'b1, 1'b1, 1'b1, 32'h200);
        chk("fs_valid", 32'(ifid_valid_o), 32'd0);
        chk("fs_pc", pc_o, 32'h200);

        // reset during an outstanding fetch; the late rvalid must be ignored
        lat = 4;
        k = 0;
        while (!m_out && k < 20) begin step(); k++; end
        rst = 1'b0;
        #1;
        model_reset();
        chk("rst_req", 32'(imem_req_o), 32'd0);
        chk("rst_ifid_pc", ifid_pc_o, 32'h0);
        step();
        rst = 1'b1;
        #1;
        k = 0;
        while (!ifid_valid_o && k < 30) begin step(); k++; end
        chk("rst_first_pc", ifid_pc_o, RESET_PC);
        tick(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
        chk("wrap_plus4", pc_plus4_o, 32'h0);
        k = 0;
        while (!ifid_valid_o && k < 30) begin step(); k++; end
        chk("wrap_ifid_pc", ifid_pc_o, 32'hFFFF_FFFC);
        chk("wrap_pc", pc_o, 32'h0);

        // randomized traffic
        rnd_mem = 1'b1;
        for (int i = 0; i < 600; i++) begin
            fl = ($urandom_range(0, 9) == 0);
            st = ($urandom_range(0, 3) == 0);
            ut = ($urandom_range(0, 7) == 0);
            r  = $urandom;
            r[1:0] = 2'b00;
            if ($urandom_range(0, 15) == 0) r = 32'hFFFF_FFFC;
            tick(fl, st, ut, r);
        end
        check_all();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
